// File: rtl/fetch_unit_if.sv
// Fetch front-end bus: instruction-memory port, redirect input and decode handshake.
// The master side is the fetch unit; the slave side is memory, branch unit and decode.
`timescale 1ns/1ps
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        input  redirect_valid, redirect_pc,
        output out_valid, out_instr, out_pc,
        input  out_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        output redirect_valid, redirect_pc,
        input  out_valid, out_instr, out_pc,
        output out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, one-deep request pipeline to a synchronous
// instruction memory, and a prefetch FIFO of {pc, instr} presented to decode.
`timescale 1ns/1ps
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] PC_RESET   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  inflight_pc_q;
    logic             inflight_q;
    logic             kill_q;

    logic [XLEN-1:0]  fifo_pc    [FIFO_DEPTH];
    logic [31:0]      fifo_instr [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic             pop;
    logic             push;
    logic             issue;
    logic [OCC_W-1:0] occupancy;

    assign bus.out_valid = (count_q != '0);
    assign pop           = bus.out_valid & bus.out_ready;
    assign push          = inflight_q & ~kill_q & ~bus.redirect_valid;

    // Credit check: a request is only issued if its response is guaranteed a FIFO slot.
    assign occupancy = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
    assign issue     = ~reset & ~bus.redirect_valid & (occupancy < OCC_W'(FIFO_DEPTH));

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc_q;

    assign bus.out_instr = bus.out_valid ? fifo_instr[rd_ptr_q] : '0;
    assign bus.out_pc    = bus.out_valid ? fifo_pc[rd_ptr_q]    : '0;

    // NOTE: registers use <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= PC_RESET;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            kill_q        <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            kill_q     <= bus.redirect_valid & inflight_q;
            inflight_q <= issue;
            if (issue) begin
                pc_q          <= pc_q + XLEN'(4);
                inflight_pc_q <= pc_q;
            end
            // Redirect flushes everything; a pop in the same cycle has already been taken by decode.
            if (bus.redirect_valid) begin
                pc_q     <= bus.redirect_pc & ~XLEN'(3);
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; out_valid gates the head so stale words never escape.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr_q]    <= inflight_pc_q;
            fifo_instr[wr_ptr_q] <= bus.imem_rdata;
        end
    end
endmodule
